operand_mux_pipe: RTL and testbench

OPERAND_MUX_PIPE -- requirements
Module: operand_mux_pipe

---
 rtl/opmux_pkg.sv | 12 +
 rtl/mux_n.sv | 27 ++
 rtl/operand_mux_pipe.sv | 114 +++++++++++
 tb/tb_operand_mux_pipe.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/opmux_pkg.sv
// Shared constants and select-width derivation for the operand mux pipeline.
package opmux_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_N_IN  = 4;

    // Select width is never allowed to collapse to zero bits.
    function automatic int sel_width(input int n_in);
        return (n_in <= 2) ? 1 : $clog2(n_in);
    endfunction

endpackage

// File: rtl/mux_n.sv
// Combinational N-way word selector; an out-of-range select yields all-zero data.
module mux_n
    import opmux_pkg::*;
#(
    parameter int  WIDTH = DEFAULT_WIDTH,
    parameter int  N_IN  = DEFAULT_N_IN,
    localparam int SEL_W = sel_width(N_IN)
) (
    input  logic [N_IN*WIDTH-1:0] data,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      out,
    output logic                  out_of_range
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        out          = '0;
        out_of_range = 1'b1;
        for (int k = 0; k < N_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                out          = data[k*WIDTH +: WIDTH];
                out_of_range = 1'b0;
            end
        end
    end

endmodule

// File: rtl/operand_mux_pipe.sv
// Registered operand selector with valid/ready handshake, flush and sticky select error.
// Define OPMUX_SKID_EN for a 2-entry skid buffer with registered in_ready_o.
module operand_mux_pipe
    import opmux_pkg::*;
#(
    parameter int  WIDTH = DEFAULT_WIDTH,
    parameter int  N_IN  = DEFAULT_N_IN,
    localparam int SEL_W = sel_width(N_IN)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_IN*WIDTH-1:0] in_data_i,
    input  logic [SEL_W-1:0]      sel_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  flush_i,
    output logic [WIDTH-1:0]      out_data_o,
    output logic [SEL_W-1:0]      out_sel_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic                  sel_err_o
);

    logic [WIDTH-1:0] mux_data;
    logic             mux_err;
    logic             accept;
    logic             out_free;

    mux_n #(
        .WIDTH (WIDTH),
        .N_IN  (N_IN)
    ) u_mux (
        .data         (in_data_i),
        .sel          (sel_i),
        .out          (mux_data),
        .out_of_range (mux_err)
    );

    assign out_free = !out_valid_o || out_ready_i;
    assign accept   = in_valid_i && in_ready_o;

    // A flushed input is never stored, so it cannot raise the error flag either.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
        if (rst_i) begin
            sel_err_o <= 1'b0;
        end else if (accept && !flush_i && mux_err) begin
            sel_err_o <= 1'b1;
        end
    end

`ifdef OPMUX_SKID_EN
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic [SEL_W-1:0] skid_sel;

    // Only registered state feeds in_ready_o; out_ready_i never reaches it.
    assign in_ready_o = !skid_valid && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_sel_o   <= '0;
            skid_valid  <= 1'b0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
            skid_valid  <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid_o <= 1'b1;
                out_data_o  <= skid_data;
                out_sel_o   <= skid_sel;
                skid_valid  <= 1'b0;
            end else if (accept) begin
                out_valid_o <= 1'b1;
                out_data_o  <= mux_data;
                out_sel_o   <= sel_i;
            end else begin
                out_valid_o <= 1'b0;
            end
        end else if (accept) begin
            skid_valid <= 1'b1;
        end
    end

    // NOTE: payload registers carry no reset; skid_valid alone decides whether they mean anything.
    always_ff @(posedge clk_i) begin
        if (accept && !out_free) begin
            skid_data <= mux_data;
            skid_sel  <= sel_i;
        end
    end
`else
    assign in_ready_o = out_free && !rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_sel_o   <= '0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (accept) begin
            out_valid_o <= 1'b1;
            out_data_o  <= mux_data;
            out_sel_o   <= sel_i;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_operand_mux_pipe.sv
// Directed bench for operand_mux_pipe (N_IN=4 and N_IN=3 instances share stimulus),
// followed by a randomized valid/ready run against a queue reference model.
module tb_operand_mux_pipe;

`ifdef OPMUX_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    localparam logic [31:0] WA = 32'h0000_000A;
    localparam logic [31:0] WB = 32'h0000_000B;
    localparam logic [31:0] WC = 32'h0000_000C;
    localparam logic [31:0] WD = 32'h0000_000D;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] in_data = {WD, WC, WB, WA};
    logic [1:0]   sel = 2'd0;
    logic         in_valid = 1'b0;
    logic         flush = 1'b0;
    logic         out_ready = 1'b0;

    logic         in_ready4, out_valid4, err4;
    logic [31:0]  out_data4;
    logic [1:0]   out_sel4;
    logic         in_ready3, out_valid3, err3;
    logic [31:0]  out_data3;
    logic [1:0]   out_sel3;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] got[$];
    int          nxt, n_send, sel_mod;

    always #5 clk = ~clk;

    operand_mux_pipe #(.WIDTH(32), .N_IN(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .sel_i(sel),
        .in_valid_i(in_valid), .in_ready_o(in_ready4), .flush_i(flush),
        .out_data_o(out_data4), .out_sel_o(out_sel4), .out_valid_o(out_valid4),
        .out_ready_i(out_ready), .sel_err_o(err4)
    );

    operand_mux_pipe #(.WIDTH(32), .N_IN(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .in_data_i(in_data[95:0]), .sel_i(sel),
        .in_valid_i(in_valid), .in_ready_o(in_ready3), .flush_i(flush),
        .out_data_o(out_data3), .out_sel_o(out_sel3), .out_valid_o(out_valid3),
        .out_ready_i(out_ready), .sel_err_o(err3)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One handshake cycle of a directed stream; advances to the next word only when accepted.
    task automatic run_cycle();
        logic acc, xfer;
        #1;
        acc  = in_valid && in_ready4;
        xfer = out_valid4 && out_ready;
        if (xfer) got.push_back(out_data4);
        tick();
        if (acc) nxt++;
        sel      = 2'(nxt % sel_mod);
        in_valid = (nxt < n_send);
    endtask

    task automatic single_sel2(input string tag);
        out_ready = 1'b1;
        sel       = 2'd2;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_valid"}, out_valid4, 1);
        check({tag, "_data"},  out_data4, WC);
        check({tag, "_sel"},   out_sel4, 2);
        tick();
        check({tag, "_drained"}, out_valid4, 0);
        check({tag, "_retain"},  out_data4, WC);
    endtask

    function automatic logic [31:0] word_of(input int idx);
        case (idx)
            0: return WA;
            1: return WB;
            2: return WC;
            default: return WD;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [33:0] q[$];
        logic [31:0] w[4];
        int          n_xfer, vcnt;

        // Reset state.
        tick();
        tick();
        check("rst_valid", out_valid4, 0);
        check("rst_data",  out_data4, 0);
        check("rst_sel",   out_sel4, 0);
        check("rst_err",   err4, 0);
        check("rst_ready", in_ready4, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", in_ready4, 1);

        // Single accept, latency 1.
        single_sel2("s1");

        // Back-to-back stream with a 3-cycle downstream stall.
        got.delete();
        nxt = 0; n_send = 4; sel_mod = 4;
        out_ready = 1'b0;
        sel = 2'd0;
        in_valid = 1'b1;
        run_cycle();
        check("s2_stall1_data", out_data4, WA);
        check("s2_stall1_ready", in_ready4, SKID ? 1 : 0);
        run_cycle();
        check("s2_stall2_data", out_data4, WA);
        check("s2_stall2_ready", in_ready4, 0);
        run_cycle();
        check("s2_stall3_data", out_data4, WA);
        check("s2_stall3_valid", out_valid4, 1);
        out_ready = 1'b1;
        repeat (8) run_cycle();
        check("s2_count", got.size(), 4);
        for (int i = 0; i < got.size() && i < 4; i++) check("s2_order", got[i], word_of(i));

        // Out-of-range select on the N_IN=3 instance.
        in_valid = 1'b0;
        out_ready = 1'b1;
        sel = 2'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("s3_data3", out_data3, 0);
        check("s3_err3", err3, 1);
        check("s3_data4", out_data4, WD);
        check("s3_err4", err4, 0);
        tick();
        got.delete();
        nxt = 0; n_send = 10; sel_mod = 3;
        sel = 2'd0;
        in_valid = 1'b1;
        repeat (13) run_cycle();
        check("s3_count", got.size(), 10);
        for (int i = 0; i < got.size() && i < 10; i++) check("s3_order", got[i], word_of(i % 3));
        check("s3_err3_sticky", err3, 1);
        check("s3_err4_clean", err4, 0);

        // Flush with buffered entries and a simultaneous offer.
        in_valid = 1'b0;
        out_ready = 1'b0;
        sel = 2'd0;
        in_valid = 1'b1;
        tick();
        sel = 2'd2;
        tick();
        check("s4_full_ready", in_ready4, 0);
        flush = 1'b1;
        sel = 2'd1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("s4_valid", out_valid4, 0);
        check("s4_ready", in_ready4, 1);
        check("s4_data_kept", out_data4, WA);
        check("s4_err3_kept", err3, 1);
        out_ready = 1'b1;
        vcnt = 0;
        repeat (4) begin
            vcnt += int'(out_valid4);
            tick();
        end
        check("s4_no_emit", vcnt, 0);

        // Reset mid-stream with a valid output and a set error flag.
        out_ready = 1'b0;
        sel = 2'd3;
        in_valid = 1'b1;
        tick();
        check("s5_pre_valid", out_valid4, 1);
        check("s5_pre_err3", err3, 1);
        sel = 2'd1;
        rst = 1'b1;
        #1;
        check("s5_ready4", in_ready4, 0);
        check("s5_ready3", in_ready3, 0);
        tick();
        check("s5_valid4", out_valid4, 0);
        check("s5_data4", out_data4, 0);
        check("s5_sel4", out_sel4, 0);
        check("s5_err3", err3, 0);
        check("s5_valid3", out_valid3, 0);
        check("s5_data3", out_data3, 0);
        rst = 1'b0;
        in_valid = 1'b0;
        single_sel2("s5_after");

        // Randomized valid/ready against a FIFO reference model.
        q.delete();
        n_xfer = 0;
        for (int cyc = 0; cyc < 20000 && n_xfer < 2000; cyc++) begin
            for (int k = 0; k < 4; k++) w[k] = $urandom;
            in_data   = {w[3], w[2], w[1], w[0]};
            sel       = 2'($urandom_range(3));
            in_valid  = 1'($urandom_range(1));
            out_ready = 1'($urandom_range(1));
            #1;
            if (out_valid4 && out_ready) begin
                check("rnd_nonempty", (q.size() != 0), 1);
                if (q.size() != 0) check("rnd_data", {out_sel4, out_data4}, q.pop_front());
                n_xfer++;
            end
            if (in_valid && in_ready4) q.push_back({sel, w[sel]});
            tick();
        end
        check("rnd_count", n_xfer, 2000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
